// File: rtl/serial_sub16_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Master drives the request, slave returns the result and status.
interface serial_sub16_if;
  logic        start;
  logic [15:0] A1;
  logic [15:0] A2;
  logic        bin;
  logic [15:0] D;
  logic        B;
  logic        V;
  logic        busy;
  logic        done;

  modport master (output start, A1, A2, bin, input D, B, V, busy, done);
  modport slave  (input start, A1, A2, bin, output D, B, V, busy, done);
endinterface

// File: rtl/serial_sub16.sv
// Bit-serial 16-bit subtractor: D = A1 - A2 - bin, one full-subtractor
// step per clock, LSB first, result valid 16 cycles after start.
module serial_sub16 (
  input logic           clk,
  input logic           rst,
  serial_sub16_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  state;
  logic [15:0] sa, sb, res;
  logic [3:0]  cnt;
  logic        br, a_msb, b_msb;
  logic        a, b, d, br_nxt;

  assign a      = sa[0];
  assign b      = sb[0];
  assign d      = a ^ b ^ br;
  assign br_nxt = (~a & b) | (~(a ^ b) & br);

  assign bus.busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      res      <= '0;
      cnt      <= '0;
      br       <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      bus.D    <= '0;
      bus.B    <= 1'b0;
      bus.V    <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa    <= bus.A1;
            sb    <= bus.A2;
            br    <= bus.bin;
            // operand MSBs are shifted out, keep them for the overflow test
            a_msb <= bus.A1[15];
            b_msb <= bus.A2[15];
            cnt   <= '0;
            res   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sa  <= {1'b0, sa[15:1]};
          sb  <= {1'b0, sb[15:1]};
          br  <= br_nxt;
          res <= {d, res[15:1]};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            bus.D    <= {d, res[15:1]};
            bus.B    <= br_nxt;
            bus.V    <= (a_msb != b_msb) && (d != a_msb);
            bus.done <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
